prog_seq_counter: RTL and testbench
===================================

// Module: prog_seq_counter
// PURPOSE
//  Parametrised Moore-FSM sequence counter: steps through a DEPTH-entry table of WIDTH-bit codes.
//  Supports forward, reverse, ping-pong and hold modes, a runtime-writable table, index load and a wrap flag.
//  Defaults reproduce the 1-7-3-5 / 1-5-3-7 counter. Serves as the sequence/pattern source for lab datapaths.
// PARAMETERS
//  WIDTH    3                             code width in bits
//  DEPTH    4                             table entries, >=1
//  IDX_W    $clog2(DEPTH) (min 1)         index width, derived; do not override
//  INIT_SEQ {3'd5,3'd3,3'd7,3'd1}         DEPTH*WIDTH packed reset table, entry 0 in LSBs
// PORTS
//  clk      in   1         clock, all state updates on posedge
//  reset    in   1         synchronous, active-high
//  enable   in   1         advance one step this edge
//  mode     in   2         00 FWD, 01 REV, 10 PING, 11 HOLD
//  load     in   1         load index from load_idx this edge
//  load_idx in   IDX_W     index to load
//  wr_en    in   1         write table entry
//  wr_addr  in   IDX_W     table address
//  wr_data  in   WIDTH     table data
//  count    out  WIDTH     table[idx], Moore output
//  idx      out  IDX_W     current index
//  wrap     out  1         registered one-cycle pulse: previous step completed a sequence pass
//  load_err out  1         registered one-cycle pulse: load with load_idx >= DEPTH
// BEHAVIOUR
//  State: idx, dir (0 up / 1 down), table[DEPTH], wrap, load_err. Reset is synchronous only.
//  Reset: idx=0, dir=0, table=INIT_SEQ, wrap=0, load_err=0. count=INIT_SEQ[0] (1) in the cycle after the reset edge.
//  Priority per edge: reset > load > enable step > hold.
//  load with load_idx < DEPTH: idx<=load_idx, dir<=0, wrap<=0. Same-cycle enable ignored.
//  load with load_idx >= DEPTH: idx unchanged; load_err<=1 next cycle. Same-cycle enable is also ignored.
//  Step (enable=1, load=0):
//   FWD: idx<=(idx==DEPTH-1)?0:idx+1; wrap<=1 when idx goes DEPTH-1 -> 0.
//   REV: idx<=(idx==0)?DEPTH-1:idx-1; wrap<=1 when idx goes 0 -> DEPTH-1.
//   PING: 0,1..DEPTH-1,DEPTH-2..0,1... Endpoints visited once per turn.
//         dir=0 at DEPTH-1: dir<=1, idx<=DEPTH-2.
//         dir=1 at 0: dir<=0, idx<=1.
//         wrap<=1 on arrival at idx 0.
//   HOLD: no change.
//  DEPTH==1: idx stays 0 in every mode; wrap pulses on every enabled non-HOLD step.
//  enable=0 or HOLD: idx, dir and count hold; wrap<=0.
//  wrap and load_err deassert on the following edge unless re-triggered.
//  Mode changes apply on the next step from the current idx. dir persists across modes; only PING uses or updates it.
//   Entering PING at idx DEPTH-1 with dir=0 turns down at once.
//  count = table[idx], combinational from registers with no input path (Moore); 0-cycle latency from idx.
//  Table write: table[wr_addr]<=wr_data at the edge. Writes are accepted during steps and loads; ignored during reset.
//   Writing the current or next idx: count shows the new data from the cycle after the edge.
//  Width: idx arithmetic is modulo the explicit DEPTH compare, never 2^IDX_W. Non-power-of-2 DEPTH is required to work.
// STRUCTURE
//  Package seq_counter_pkg: mode localparams (MODE_FWD, MODE_REV, MODE_PING, MODE_HOLD) and the dir encoding.
//  Sub-module seq_table: DEPTH x WIDTH register file, synchronous write, async read, reset-loaded from INIT_SEQ.
//  Top: index/dir FSM (next-state always block plus registered state) and the flag registers.
// TESTING
//  1 reset, mode=00, enable=1 for 8 cycles -> count 1,7,3,5,1,7,3,5; wrap high the cycle after each 5->1.
//  2 mode=01 from reset, enable=1 -> count 1,5,3,7,1; enable=0 for 3 cycles -> count holds, wrap=0.
//  3 mode=10 from reset, enable=1 for 8 cycles -> idx 1,2,3,2,1,0,1,2; wrap pulses once, after arrival at idx 0.
//  4 load=1, load_idx=2, enable=1 -> idx=2, count=3, no step.
//    DEPTH=4 with load_idx out of range is untestable (IDX_W=2); cover it with the DEPTH=5 bench: load_idx=7 -> idx unchanged, load_err one cycle.
//  5 wr_en, wr_addr=idx, wr_data=6 with enable=0 -> count=6 next cycle.
//    Reset asserted mid-sequence at idx 3 -> idx 0, count 1, table restored.
//  6 DEPTH=5, WIDTH=4, FWD for 10 steps -> idx wraps 4->0 (never 5..7), wrap twice.
//    DEPTH=1 -> idx stays 0, wrap every step.

Source files
------------

// File: rtl/prog_seq_counter_pkg.sv
// Shared encodings for the programmable sequence counter: step modes and ping-pong direction.
// Pure definitions; no latency or backpressure.
package seq_counter_pkg;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/prog_seq_counter_seq_table.sv
// DEPTH x WIDTH code table with synchronous write and asynchronous read, reloaded from INIT_SEQ on reset.
// Latency: a write shows on rd_data the cycle after its edge; no backpressure, writes always accepted.
module seq_table #(
    parameter int                     WIDTH    = 3,
    parameter int                     DEPTH    = 4,
    parameter int                     IDX_W    = 2,
    parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [31:0]      wr_addr_ext;

    assign wr_addr_ext = 32'(wr_addr);

    // Addresses past DEPTH-1 exist when DEPTH is not a power of two; drop those writes.
    always_comb begin
        mem_d = mem_q;
        if (wr_en && (wr_addr_ext < 32'(DEPTH))) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= INIT_SEQ[i*WIDTH +: WIDTH];
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/prog_seq_counter.sv
// Moore sequence counter stepping through a writable code table in forward, reverse, ping-pong or hold mode.
// Latency: count follows idx with zero delay; wrap/load_err are one-cycle registered pulses; no backpressure.
module prog_seq_counter
    import seq_counter_pkg::*;
#(
    parameter int                     WIDTH    = 3,
    parameter int                     DEPTH    = 4,
    parameter int                     IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter logic [DEPTH*WIDTH-1:0] INIT_SEQ = {3'd5, 3'd3, 3'd7, 3'd1}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] count,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             load_err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    dir_e             dir_q, dir_d;
    logic             wrap_q, wrap_d;
    logic             load_err_q, load_err_d;
    logic             load_ok;

    assign load_ok = (32'(load_idx) < 32'(DEPTH));

    always_comb begin
        idx_d      = idx_q;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                idx_d = load_idx;
                dir_d = DIR_UP;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (enable && (mode != MODE_HOLD)) begin
            if (DEPTH == 1) begin
                wrap_d = 1'b1;
            end else begin
                case (mode)
                    MODE_FWD: begin
                        idx_d  = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
                        wrap_d = (idx_q == LAST);
                    end
                    MODE_REV: begin
                        idx_d  = (idx_q == '0) ? LAST : idx_q - IDX_W'(1);
                        wrap_d = (idx_q == '0);
                    end
                    MODE_PING: begin
                        // Turn at the endpoints so each end is visited once per pass.
                        if (dir_q == DIR_UP) begin
                            if (idx_q == LAST) begin
                                dir_d = DIR_DOWN;
                                idx_d = LAST - IDX_W'(1);
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            if (idx_q == '0) begin
                                dir_d = DIR_UP;
                                idx_d = IDX_W'(1);
                            end else begin
                                idx_d = idx_q - IDX_W'(1);
                            end
                        end
                        wrap_d = (idx_d == '0);
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            dir_q      <= DIR_UP;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    seq_table #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .IDX_W   (IDX_W),
        .INIT_SEQ(INIT_SEQ)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_addr(idx_q),
        .rd_data(count)
    );

    assign idx      = idx_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_prog_seq_counter.sv
// Bench for prog_seq_counter: DEPTH=4 (defaults), DEPTH=5/WIDTH=4 and DEPTH=1 instances share one stimulus stream.
module tb_prog_seq_counter;

    logic       clk = 1'b0;
    logic       reset, enable, load, wr_en;
    logic [1:0] mode;
    logic [2:0] load_idx, wr_addr;
    logic [3:0] wr_data;

    logic [2:0] count4; logic [1:0] idx4; logic wrap4, lerr4;
    logic [3:0] count5; logic [2:0] idx5; logic wrap5, lerr5;
    logic [2:0] count1; logic [0:0] idx1; logic wrap1, lerr1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model state, one row per instance: 0 = DEPTH 4, 1 = DEPTH 5, 2 = DEPTH 1.
    int dep[3]       = '{4, 5, 1};
    int iw[3]        = '{2, 3, 1};
    int wd[3]        = '{3, 4, 3};
    int m_init[3][5] = '{'{1, 7, 3, 5, 0}, '{2, 3, 6, 9, 12}, '{4, 0, 0, 0, 0}};
    int m_tbl[3][5];
    int m_idx[3];
    bit m_down[3];
    bit m_wrap[3];
    bit m_lerr[3];

    int exp_fwd_cnt[8]  = '{7, 3, 5, 1, 7, 3, 5, 1};
    int exp_fwd_wrap[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int exp_rev_cnt[4]  = '{5, 3, 7, 1};
    int exp_ping_idx[8] = '{1, 2, 3, 2, 1, 0, 1, 2};
    int exp_d5_idx[10]  = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    always #5 clk = ~clk;

    prog_seq_counter u4 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .load(load), .load_idx(load_idx[1:0]),
        .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data[2:0]),
        .count(count4), .idx(idx4), .wrap(wrap4), .load_err(lerr4)
    );

    prog_seq_counter #(
        .WIDTH(4), .DEPTH(5), .INIT_SEQ({4'd12, 4'd9, 4'd6, 4'd3, 4'd2})
    ) u5 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .load(load), .load_idx(load_idx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count5), .idx(idx5), .wrap(wrap5), .load_err(lerr5)
    );

    prog_seq_counter #(
        .WIDTH(3), .DEPTH(1), .INIT_SEQ(3'd4)
    ) u1 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .load(load), .load_idx(load_idx[0:0]),
        .wr_en(wr_en), .wr_addr(wr_addr[0:0]), .wr_data(wr_data[2:0]),
        .count(count1), .idx(idx1), .wrap(wrap1), .load_err(lerr1)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Ping-pong is modelled as a phase around a ring of 2*DEPTH-2 positions.
    task automatic model_tick(int m);
        int d, li, wa, ni, p, per;
        bit nw, nl;
        d  = dep[m];
        li = int'(load_idx) % (1 << iw[m]);
        wa = int'(wr_addr) % (1 << iw[m]);
        if (reset) begin
            m_idx[m] = 0; m_down[m] = 1'b0; m_wrap[m] = 1'b0; m_lerr[m] = 1'b0;
            for (int k = 0; k < 5; k++) m_tbl[m][k] = m_init[m][k];
            return;
        end
        ni = m_idx[m]; nw = 1'b0; nl = 1'b0;
        if (load) begin
            if (li < d) begin
                ni = li;
                m_down[m] = 1'b0;
            end else begin
                nl = 1'b1;
            end
        end else if (enable && mode != 2'd3) begin
            case (mode)
                2'd0: begin ni = (m_idx[m] + 1) % d; nw = (ni == 0); end
                2'd1: begin ni = (m_idx[m] + d - 1) % d; nw = (m_idx[m] == 0); end
                default: begin
                    if (d == 1) begin
                        ni = 0;
                    end else begin
                        per = 2 * d - 2;
                        p   = m_down[m] ? (per - m_idx[m]) % per : m_idx[m];
                        p   = (p + 1) % per;
                        ni  = (p < d) ? p : per - p;
                        m_down[m] = (p >= d) || (p == 0);
                    end
                    nw = (ni == 0);
                end
            endcase
        end
        if (wr_en && wa < d) m_tbl[m][wa] = int'(wr_data) % (1 << wd[m]);
        m_idx[m] = ni; m_wrap[m] = nw; m_lerr[m] = nl;
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 3; m++) model_tick(m);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("d4 count", 32'(count4), m_tbl[0][m_idx[0]]);
            check("d4 idx",   32'(idx4),   m_idx[0]);
            check("d4 wrap",  32'(wrap4),  m_wrap[0]);
            check("d4 lerr",  32'(lerr4),  m_lerr[0]);
            check("d5 count", 32'(count5), m_tbl[1][m_idx[1]]);
            check("d5 idx",   32'(idx5),   m_idx[1]);
            check("d5 wrap",  32'(wrap5),  m_wrap[1]);
            check("d5 lerr",  32'(lerr5),  m_lerr[1]);
            check("d1 count", 32'(count1), m_tbl[2][m_idx[2]]);
            check("d1 idx",   32'(idx1),   m_idx[2]);
            check("d1 wrap",  32'(wrap1),  m_wrap[2]);
            check("d1 lerr",  32'(lerr1),  m_lerr[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int wsum;
        reset = 1'b1; enable = 1'b0; mode = 2'd0; load = 1'b0;
        load_idx = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        check("rst count", 32'(count4), 1);
        check("rst idx", 32'(idx4), 0);
        check("rst wrap", 32'(wrap4), 0);
        check("rst lerr", 32'(lerr4), 0);
        check("rst d5 count", 32'(count5), 2);
        check("rst d1 count", 32'(count1), 4);

        // Forward pass twice.
        reset = 1'b0; enable = 1'b1; mode = 2'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("fwd count", 32'(count4), exp_fwd_cnt[i]);
            check("fwd wrap", 32'(wrap4), exp_fwd_wrap[i]);
        end

        // Reverse from reset, then hold with enable low.
        reset = 1'b1; tick(); reset = 1'b0; mode = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rev count", 32'(count4), exp_rev_cnt[i]);
            check("rev wrap", 32'(wrap4), (i == 0) ? 1 : 0);
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle count", 32'(count4), 1);
            check("idle wrap", 32'(wrap4), 0);
        end

        // Ping-pong from reset.
        reset = 1'b1; tick(); reset = 1'b0; mode = 2'd2; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("ping idx", 32'(idx4), exp_ping_idx[i]);
            check("ping wrap", 32'(wrap4), (i == 5) ? 1 : 0);
        end

        // Loads override a same-cycle step; out-of-range load on DEPTH 5.
        load = 1'b1; load_idx = 3'd2;
        tick();
        check("load idx", 32'(idx4), 2);
        check("load count", 32'(count4), 3);
        load_idx = 3'd7;
        tick();
        check("bad load d5 idx", 32'(idx5), 2);
        check("bad load d5 lerr", 32'(lerr5), 1);
        check("load d4 idx", 32'(idx4), 3);
        load = 1'b0; enable = 1'b0;
        tick();
        check("lerr clears", 32'(lerr5), 0);
        check("d5 idx kept", 32'(idx5), 2);

        // Table writes to the current and the next index.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd6;
        tick();
        check("wr cur count", 32'(count4), 6);
        wr_addr = 3'd0; wr_data = 4'd2; mode = 2'd0; enable = 1'b1;
        tick();
        check("wr next idx", 32'(idx4), 0);
        check("wr next count", 32'(count4), 2);
        check("wr next wrap", 32'(wrap4), 1);
        wr_en = 1'b0;
        tick(); check("post wr count", 32'(count4), 7);
        tick(); check("post wr count", 32'(count4), 3);
        tick(); check("post wr count", 32'(count4), 6);

        // Reset mid-sequence restores the table and ignores a concurrent write.
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd0;
        tick();
        check("midrst idx", 32'(idx4), 0);
        check("midrst count", 32'(count4), 1);
        reset = 1'b0; wr_en = 1'b0;
        tick(); check("restored count", 32'(count4), 7);
        tick(); check("restored count", 32'(count4), 3);
        tick(); check("restored count", 32'(count4), 5);

        // DEPTH 5 forward wrap and DEPTH 1 behaviour.
        reset = 1'b1; tick(); reset = 1'b0; mode = 2'd0;
        wsum = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("d5 fwd idx", 32'(idx5), exp_d5_idx[i]);
            check("d1 idx", 32'(idx1), 0);
            check("d1 wrap", 32'(wrap1), 1);
            wsum += int'(wrap5);
        end
        check("d5 wrap count", wsum, 2);
        tick();
        check("d4 pre-ping idx", 32'(idx4), 3);
        mode = 2'd2;
        tick();
        check("ping turn at once", 32'(idx4), 2);
        mode = 2'd3;
        tick();
        check("hold idx", 32'(idx4), 2);
        check("hold wrap", 32'(wrap4), 0);
        check("hold d1 wrap", 32'(wrap1), 0);

        // Mixed traffic checked against the model every cycle.
        for (int i = 0; i < 120; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            mode     = 2'($urandom_range(0, 3));
            enable   = ($urandom_range(0, 3) != 0);
            load     = ($urandom_range(0, 9) == 0);
            load_idx = 3'($urandom_range(0, 7));
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 4'($urandom_range(0, 15));
            tick();
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
